pulse_src_switch: RTL

Parametrised, glitch-free selector routing one of NCH pulse-control sources (each NSIG lines, e.g. forward/back/df) to the transmitter gate drivers of the NMR front end. A channel change is requested by strobe, takes effect only after the active source goes idle, and a programmable dead time with all outputs forced low is inserted before the new source is connected. Sits between the sequence generators and the RF/gate output stage.

---
 rtl/psw_pkg.sv | 18 +
 rtl/psw_down_cnt.sv | 28 ++
 rtl/pulse_src_switch.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/psw_pkg.sv
// Shared constants and helpers for the pulse source switch.
package psw_pkg;

  localparam int PSW_NCH_DEF  = 4;
  localparam int PSW_NSIG_DEF = 3;
  localparam int PSW_DEAD_DEF = 4;
  localparam int PSW_TMO_DEF  = 1024;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DEAD  = 2'd2;

  // Width of a source index; never below one bit.
  function automatic int psw_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/psw_down_cnt.sv
// Loadable down counter that stops at zero and flags it.
// Load has priority over decrement; the zero flag is taken from the register.
module psw_down_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_src_switch.sv
// Glitch-free selector of NCH pulse sources; output registered, 1-cycle latency. A switch waits for the
// active source to go idle, then drives all lines low for DEAD cycles. PSW_TIMEOUT_EN adds a forced drain after TMO cycles.
module pulse_src_switch
  import psw_pkg::*;
#(
  parameter int NCH  = PSW_NCH_DEF,
  parameter int NSIG = PSW_NSIG_DEF,
  parameter int DEAD = PSW_DEAD_DEF,
  parameter int TMO  = PSW_TMO_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NCH*NSIG-1:0]         src_sig,
  input  logic [psw_idx_w(NCH)-1:0]   sel_req,
  input  logic                        sel_stb,
  output logic [NSIG-1:0]             sig_out,
  output logic [psw_idx_w(NCH)-1:0]   sel_cur,
  output logic                        busy,
  output logic                        sel_ack,
  output logic                        sel_err,
  output logic                        drain_tmo
);

  localparam int IW = psw_idx_w(NCH);
  localparam int DW = 8;
  localparam logic [IW:0] NCH_W = (IW+1)'(NCH);

  if (NCH < 2 || NCH > 16 || NSIG < 1 || NSIG > 16 || DEAD < 1 || DEAD > 255 || TMO < 1) begin : g_bad_cfg
    $error("pulse_src_switch: parameter out of range");
  end

  logic [1:0]      state;
  logic [IW-1:0]   pend;
  logic [NSIG-1:0] src_arr [2**IW];
  logic [NSIG-1:0] cur_src;
  logic            cur_idle;
  logic            req_bad;
  logic            go_drain;
  logic            drain_exit;
  logic            dead_zero;
  logic            tmo_hit;

  // Unused index slots read as idle so an out-of-range select can never glitch.
  for (genvar i = 0; i < 2**IW; i++) begin : g_src
    if (i < NCH) begin : g_real
      assign src_arr[i] = src_sig[i*NSIG +: NSIG];
    end else begin : g_pad
      assign src_arr[i] = '0;
    end
  end

  assign cur_src    = src_arr[sel_cur];
  assign cur_idle   = (cur_src == '0);
  assign req_bad    = ({1'b0, sel_req} >= NCH_W);
  assign go_drain   = (state == ST_RUN) && sel_stb && !req_bad && (sel_req != sel_cur);
  assign drain_exit = (state == ST_DRAIN) && (cur_idle || tmo_hit);

`ifdef PSW_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic tmo_zero;

  psw_down_cnt #(.W(TW)) u_tmo_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (go_drain),
    .load_val (TW'(TMO - 1)),
    .dec      (state == ST_DRAIN),
    .zero     (tmo_zero)
  );

  assign tmo_hit = (state == ST_DRAIN) && !cur_idle && tmo_zero;
`else
  assign tmo_hit = 1'b0;
`endif

  psw_down_cnt #(.W(DW)) u_dead_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (drain_exit),
    .load_val (DW'(DEAD - 1)),
    .dec      (state == ST_DEAD),
    .zero     (dead_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      pend      <= '0;
      sel_cur   <= '0;
      sig_out   <= '0;
      busy      <= 1'b0;
      sel_ack   <= 1'b0;
      sel_err   <= 1'b0;
      drain_tmo <= 1'b0;
    end else begin
      sel_ack   <= 1'b0;
      sel_err   <= 1'b0;
      drain_tmo <= 1'b0;
      case (state)
        ST_RUN: begin
          sig_out <= cur_src;
          if (sel_stb) begin
            if (req_bad) begin
              sel_err <= 1'b1;
            end else if (sel_req == sel_cur) begin
              sel_ack <= 1'b1;
            end else begin
              pend  <= sel_req;
              busy  <= 1'b1;
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // The old pulse runs to completion before the output is cut.
          if (drain_exit) begin
            sig_out   <= '0;
            drain_tmo <= tmo_hit;
            state     <= ST_DEAD;
          end else begin
            sig_out <= cur_src;
          end
        end
        ST_DEAD: begin
          sig_out <= '0;
          if (dead_zero) begin
            sel_cur <= pend;
            sel_ack <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_RUN;
          end
        end
        default: begin
          sig_out <= '0;
          state   <= ST_RUN;
        end
      endcase
    end
  end

endmodule
